fetch_sequencer: RTL and testbench

Controller in front of the fetch stage of the pipelined CPU. It owns the single-port instruction memory and shares it between the fetch stage (reads) and the program loader (writes). It sequences boot, load and restart, and generates fetch/decode stall and flush controls plus PC redirects, including branch redirects from the execute stage.

---
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-side sequencer: boot/load/restart/run control, imem arbitration, redirects
module fetch_sequencer #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                IMEM_WORDS    = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter bit                BOOT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              PCSrcE,
  input  logic [ADDR_W-1:0] PCTargetE,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic [15:0]       load_count,
  output logic [31:0]       fetch_count,
  output logic              err
);

  typedef enum logic [1:0] {BOOT, LOAD, RESTART, RUN} seqState;

  // Byte limit of the memory, one bit wider than the address so the compare cannot wrap
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * longint'(IMEM_WORDS));
  localparam seqState RESET_STATE = BOOT_ON_RESET ? BOOT : RUN;

  seqState state, nextState;
  logic    beatAccepted, inRange, branchTaken, enterLoad, errEvent;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RESET_STATE;
      load_count  <= '0;
      fetch_count <= '0;
      err         <= 1'b0;
    end else begin
      state <= nextState;
      if (enterLoad)
        load_count <= '0;
      else if (beatAccepted && load_count != 16'hFFFF)
        load_count <= load_count + 16'd1;
      if (state == RUN && !StallF)
        fetch_count <= fetch_count + 32'd1;
      if (errEvent)
        err <= 1'b1;
    end
  end

  assign inRange      = {1'b0, load_addr} < MEM_BYTES;
  assign beatAccepted = load_valid && load_ready;
  // A load request in RUN wins over a same-cycle branch, which is dropped entirely
  assign branchTaken  = (state == RUN) && PCSrcE && !load_req;
  assign enterLoad    = (state != LOAD) && (nextState == LOAD);
  assign errEvent     = (branchTaken && PCTargetE[1:0] != 2'b00) ||
                        (beatAccepted && (load_addr[1:0] != 2'b00 || !inRange));

  always_comb begin
    nextState        = state;
    load_ready       = 1'b0;
    imem_addr        = load_addr;
    imem_we          = 1'b0;
    imem_wdata       = '0;
    StallF           = 1'b1;
    StallD           = 1'b1;
    FlushD           = 1'b1;
    FlushE           = 1'b1;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    unique case (state)
      BOOT: begin
        if (load_req) nextState = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        imem_wdata = load_data;
        imem_we    = load_valid && inRange;
        if (load_done) nextState = RESTART;
      end
      RESTART: begin
        StallF           = 1'b0;
        pc_redirect      = 1'b1;
        pc_redirect_addr = RESET_PC;
        nextState        = RUN;
      end
      RUN: begin
        imem_addr = fetch_pc;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = branchTaken;
        FlushE    = branchTaken;
        if (branchTaken) begin
          pc_redirect      = 1'b1;
          pc_redirect_addr = {PCTargetE[ADDR_W-1:2], 2'b00};
        end
        if (load_req) nextState = LOAD;
      end
      default: nextState = RESET_STATE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;

  localparam int IMEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst, PCSrcE, load_req, load_valid, load_done;
  logic [31:0] fetch_pc, PCTargetE, load_addr, load_data;
  logic        load_ready, imem_we, StallF, StallD, FlushD, FlushE, pc_redirect, err;
  logic [31:0] imem_addr, imem_wdata, pc_redirect_addr, fetch_count;
  logic [15:0] load_count;

  // Second instance leaves reset straight into RUN
  logic        rst2, zeroBit;
  logic [31:0] zeroWord;
  logic        load_ready2, imem_we2, StallF2, StallD2, FlushD2, FlushE2, pc_redirect2, err2;
  logic [31:0] imem_addr2, imem_wdata2, pc_redirect_addr2, fetch_count2;
  logic [15:0] load_count2;

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .load_req(load_req), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_ready(load_ready), .imem_addr(imem_addr), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr), .load_count(load_count),
    .fetch_count(fetch_count), .err(err)
  );

  fetch_sequencer #(.BOOT_ON_RESET(1'b0)) u_dut_run (
    .clk(clk), .rst(rst2), .fetch_pc(zeroWord), .PCSrcE(zeroBit), .PCTargetE(zeroWord),
    .load_req(zeroBit), .load_valid(zeroBit), .load_addr(zeroWord), .load_data(zeroWord),
    .load_done(zeroBit), .load_ready(load_ready2), .imem_addr(imem_addr2), .imem_we(imem_we2),
    .imem_wdata(imem_wdata2), .StallF(StallF2), .StallD(StallD2), .FlushD(FlushD2), .FlushE(FlushE2),
    .pc_redirect(pc_redirect2), .pc_redirect_addr(pc_redirect_addr2), .load_count(load_count2),
    .fetch_count(fetch_count2), .err(err2)
  );

  int vectors = 0;
  int miscompares = 0;
  int weCount = 0;

  typedef enum {M_BOOT, M_LOAD, M_RESTART, M_RUN} mode_e;
  mode_e       mMode = M_BOOT;
  int          mLoad = 0;
  logic [31:0] mFetch = '0;
  bit          mErr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    PCSrcE = 0; PCTargetE = '0; load_req = 0; load_valid = 0;
    load_addr = '0; load_data = '0; load_done = 0; fetch_pc = '0;
  endtask

  // One clock cycle: compare outputs against the model for the current inputs, then advance the model
  task automatic step();
    bit    acc, inRange, branch;
    mode_e nxt;
    #1;
    if (!rst) begin
      mMode = M_BOOT; mLoad = 0; mFetch = '0; mErr = 0;
    end
    inRange = longint'(load_addr) < 4 * IMEM_WORDS;
    acc     = (mMode == M_LOAD) && load_valid;
    branch  = (mMode == M_RUN) && PCSrcE && !load_req;
    check("load_ready", load_ready, mMode == M_LOAD);
    check("imem_we", imem_we, acc && inRange);
    check("imem_wdata", imem_wdata, (mMode == M_LOAD) ? load_data : 32'd0);
    check("imem_addr", imem_addr, (mMode == M_RUN) ? fetch_pc : load_addr);
    check("StallF", StallF, !(mMode == M_RUN || mMode == M_RESTART));
    if (mMode != M_RESTART) check("StallD", StallD, mMode != M_RUN);
    check("FlushD", FlushD, (mMode != M_RUN) || branch);
    check("FlushE", FlushE, (mMode != M_RUN) || branch);
    check("pc_redirect", pc_redirect, (mMode == M_RESTART) || branch);
    if (mMode == M_RESTART) check("redirect_reset_pc", pc_redirect_addr, 0);
    if (branch) check("redirect_target", pc_redirect_addr, (PCTargetE / 4) * 4);
    check("load_count", load_count, mLoad);
    check("fetch_count", fetch_count, mFetch);
    check("err", err, mErr);
    if (imem_we) weCount++;
    @(posedge clk);
    if (rst) begin
      case (mMode)
        M_BOOT:    nxt = load_req  ? M_LOAD    : M_BOOT;
        M_LOAD:    nxt = load_done ? M_RESTART : M_LOAD;
        M_RESTART: nxt = M_RUN;
        default:   nxt = load_req  ? M_LOAD    : M_RUN;
      endcase
      if ((branch && PCTargetE % 4 != 0) || (acc && (load_addr % 4 != 0 || !inRange))) mErr = 1;
      if (mMode != M_LOAD && nxt == M_LOAD) mLoad = 0;
      else if (acc && mLoad < 65535) mLoad++;
      if (mMode == M_RUN) mFetch = mFetch + 1;
      mMode = nxt;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    idle(); rst = 0; step(); rst = 1;
  endtask

  task automatic beat(input logic [31:0] addr);
    load_valid = 1; load_addr = addr; load_data = $urandom; step(); load_valid = 0;
  endtask

  task automatic finishLoad();
    load_done = 1; step(); load_done = 0; step();
  endtask

  initial begin
    rst = 0; rst2 = 0; zeroBit = 0; zeroWord = '0;
    idle();
    @(negedge clk);

    // Boot load of four words
    doReset();
    step();
    load_req = 1; step(); load_req = 0;
    weCount = 0;
    for (int i = 0; i < 4; i++) beat(32'(4 * i));
    load_done = 1; step(); load_done = 0;
    check("boot_we_cycles", weCount, 4);
    check("boot_load_count", load_count, 4);
    step();
    check("run_stallf", StallF, 0);
    for (int i = 0; i < 3; i++) begin fetch_pc = 32'(4 * i); step(); end

    // Branch redirect held two cycles, then a misaligned target
    PCSrcE = 1; PCTargetE = 72; step(); step();
    check("branch_err_clear", err, 0);
    PCTargetE = 10; step(); PCSrcE = 0;
    check("branch_err_set", err, 1);

    // Load request preempts a coincident branch
    PCSrcE = 1; PCTargetE = 32'h40; load_req = 1; step();
    idle();
    check("preempt_stallf", StallF, 1);
    step(); step();
    finishLoad();

    // Out-of-range beat
    doReset();
    load_req = 1; step(); load_req = 0;
    beat(32'(4 * IMEM_WORDS));
    check("range_err", err, 1);
    check("range_count", load_count, 1);
    finishLoad();

    // Reset in the middle of a five-beat load, then a clean reload
    doReset();
    load_req = 1; step(); load_req = 0;
    beat(32'h0); beat(32'h4);
    load_valid = 1; load_addr = 32'h8; rst = 0; step(); rst = 1; load_valid = 0;
    check("midload_count", load_count, 0);
    load_req = 1; step(); load_req = 0;
    for (int i = 0; i < 5; i++) beat(32'(4 * i));
    check("reload_count", load_count, 5);
    finishLoad();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) != 0);
      fetch_pc   = $urandom;
      PCSrcE     = ($urandom_range(0, 3) == 0);
      PCTargetE  = $urandom_range(0, 1) ? ($urandom & ~32'd3) : $urandom;
      load_req   = (mMode == M_RUN) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      load_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0, 1:    load_addr = 32'($urandom_range(0, IMEM_WORDS - 1) * 4);
        2:       load_addr = 32'($urandom_range(0, 4 * IMEM_WORDS - 1));
        default: load_addr = $urandom;
      endcase
      load_data = $urandom;
      load_done = ($urandom_range(0, 9) == 0);
      step();
    end
    idle(); rst = 1;

    // Instance that leaves reset into RUN
    @(negedge clk); #1;
    check("run_reset_stallf", StallF2, 0);
    check("run_reset_count", fetch_count2, 0);
    rst2 = 1;
    repeat (10) @(negedge clk);
    #1;
    check("run_fetch_count10", fetch_count2, 10);
    check("run_stallf_after", StallF2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
